// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, single-entry
// instruction holding register toward the decoder, halt and redirect control.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StHalted
    } state_e;

    localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    // Next-state: reset beats redirect, redirect beats every normal transition.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (reset) begin
            state_d    = halt ? StHalted : StFetch;
            pc_d       = ResetPcAligned;
            instr_d    = 32'h0;
            instr_pc_d = 32'h0;
        end else if (redirect) begin
            // Any ack arriving this cycle belongs to the old stream and is dropped.
            state_d = halt ? StHalted : StFetch;
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            unique case (state_q)
                StFetch: begin
                    // Halt is not checked here so an issued request always completes.
                    if (mem_ack) begin
                        instr_d    = mem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = StHold;
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        state_d = halt ? StHalted : StFetch;
                    end
                end
                StHalted: begin
                    if (!halt) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    // State and datapath registers; reset handled in the next-state logic.
    always_ff @(posedge clock) begin
        state_q    <= state_d;
        pc_q       <= pc_d;
        instr_q    <= instr_d;
        instr_pc_q <= instr_pc_d;
    end

    // Outputs decoded purely from registers.
    always_comb begin
        mem_req     = (state_q == StFetch);
        mem_addr    = pc_q;
        instr_valid = (state_q == StHold);
        instr       = instr_q;
        instr_pc    = instr_pc_q;
    end

endmodule
